// File: rtl/reg_bus_reader_pkg.sv
// Shared definitions for the register-bus read controller.
//   state_t      : controller states (IDLE, DRIVE, HOLD)
//   DEF_WIDTH    : default bus/data width
//   DEF_NUM_REGS : default number of registers on the bus
//   aw_of()      : register-index width for a given register count
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 32;

  function automatic int aw_of(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_bus_reader_if.sv
// Request / bus / read-data signal bundle for reg_bus_reader.
//   req_valid, req_ready, req_addr, req_cnt : burst request handshake
//   oe, bus                                 : one-hot register enables, shared bus
//   rd_valid, rd_ready, rd_data, rd_addr,
//   rd_last                                 : returned word handshake
// Modports: slave = the reader, master = requester/consumer/register side.
interface reg_bus_reader_if #(
  parameter int WIDTH    = reg_bus_pkg::DEF_WIDTH,
  parameter int NUM_REGS = reg_bus_pkg::DEF_NUM_REGS
);
  localparam int AW = reg_bus_pkg::aw_of(NUM_REGS);

  logic                req_valid;
  logic                req_ready;
  logic [AW-1:0]       req_addr;
  logic [AW-1:0]       req_cnt;
  logic [NUM_REGS-1:0] oe;
  logic [WIDTH-1:0]    bus;
  logic                rd_valid;
  logic                rd_ready;
  logic [WIDTH-1:0]    rd_data;
  logic [AW-1:0]       rd_addr;
  logic                rd_last;

  modport slave (
    input  req_valid, req_addr, req_cnt, bus, rd_ready,
    output req_ready, oe, rd_valid, rd_data, rd_addr, rd_last
  );

  modport master (
    output req_valid, req_addr, req_cnt, bus, rd_ready,
    input  req_ready, oe, rd_valid, rd_data, rd_addr, rd_last
  );
endinterface

// File: rtl/reg_bus_reader_onehot_decoder.sv
// Index to one-hot decoder with enable.
//   en     : when low the output is all-zero
//   idx    : AW-bit index
//   onehot : NUM_REGS-bit output, bit idx set when enabled
module onehot_decoder #(
  parameter int AW       = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                en,
  input  logic [AW-1:0]       idx,
  output logic [NUM_REGS-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/reg_bus_reader.sv
// Burst read controller for a shared tristate register bus.
// Walks registers cur_addr.. with a one-hot oe, waits SETTLE extra cycles,
// captures the bus word and hands it out over a valid/ready handshake.
// Ports:
//   clk   : clock, rising edge
//   clr_n : synchronous active-low reset
//   bif   : reg_bus_reader_if.slave (request, oe/bus, read-data handshake)
module reg_bus_reader
  import reg_bus_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int SETTLE   = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  reg_bus_reader_if.slave  bif
);
  localparam int          AW       = aw_of(NUM_REGS);
  localparam logic [2:0]  SETTLE_L = 3'(SETTLE);

  state_t           state, state_n;
  logic [AW-1:0]    cur_addr;
  logic [AW-1:0]    remain;
  logic [2:0]       settle_cnt;
  logic [WIDTH-1:0] rd_data_q;
  logic [AW-1:0]    rd_addr_q;
  logic             rd_last_q;

  logic accept;
  logic capture;
  logic advance;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    unique case (state)
      IDLE: begin
        if (bif.req_valid) begin
          accept  = 1'b1;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == SETTLE_L) begin
          capture = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (bif.rd_ready) begin
          if (rd_last_q) begin
            state_n = IDLE;
          end else begin
            advance = 1'b1;
            state_n = DRIVE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remain     <= '0;
      settle_cnt <= '0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cur_addr   <= bif.req_addr;
        remain     <= bif.req_cnt;
        settle_cnt <= '0;
      end
      // Counter clears on capture so the next DRIVE starts from 0.
      if (state == DRIVE) begin
        settle_cnt <= capture ? '0 : settle_cnt + 3'd1;
      end
      if (capture) begin
        rd_data_q <= bif.bus;
        rd_addr_q <= cur_addr;
        rd_last_q <= (remain == '0);
      end
      if (advance) begin
        cur_addr <= cur_addr + AW'(1);
        remain   <= remain - AW'(1);
      end
    end
  end

  onehot_decoder #(
    .AW       (AW),
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .en     (state == DRIVE),
    .idx    (cur_addr),
    .onehot (bif.oe)
  );

  assign bif.req_ready = (state == IDLE);
  assign bif.rd_valid  = (state == HOLD);
  assign bif.rd_data   = rd_data_q;
  assign bif.rd_addr   = rd_addr_q;
  assign bif.rd_last   = rd_last_q;

endmodule

// File: tb/tb_reg_bus_reader.sv
// Directed bench for reg_bus_reader: a SETTLE=1 instance for the main
// sequence and a SETTLE=0 instance for the short-pulse build.
module tb_reg_bus_reader;
  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  reg_bus_reader_if #(.WIDTH(32), .NUM_REGS(32)) ifc  ();
  reg_bus_reader_if #(.WIDTH(32), .NUM_REGS(32)) ifc0 ();

  reg_bus_reader #(.WIDTH(32), .NUM_REGS(32), .SETTLE(1)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bif   (ifc)
  );

  reg_bus_reader #(.WIDTH(32), .NUM_REGS(32), .SETTLE(0)) dut0 (
    .clk   (clk),
    .clr_n (clr_n),
    .bif   (ifc0)
  );

  logic [31:0] regs [32];

  // Register file model: only the enabled register drives, otherwise float.
  always_comb begin
    ifc.bus = 'z;
    for (int i = 0; i < 32; i++) if (ifc.oe[i]) ifc.bus = regs[i];
  end
  always_comb begin
    ifc0.bus = 'z;
    for (int i = 0; i < 32; i++) if (ifc0.oe[i]) ifc0.bus = regs[i];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst with rd_ready held high; optionally presents a stray
  // request at cycle 'inject' (counted from the request cycle = 0).
  task automatic do_burst(input int addr, input int cnt, input int inject,
                          output int words, output int last_cyc);
    int cyc;
    bit done;
    int exp_a;
    words = 0; last_cyc = -1; done = 0;
    ifc.req_valid = 1'b1;
    ifc.req_addr  = 5'(addr);
    ifc.req_cnt   = 5'(cnt);
    ifc.rd_ready  = 1'b1;
    tick();
    ifc.req_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (cyc == inject) begin
        ifc.req_valid = 1'b1;
        ifc.req_addr  = 5'd7;
        ifc.req_cnt   = 5'd0;
        chk("stray_req_ready", ifc.req_ready, 0);
      end else begin
        ifc.req_valid = 1'b0;
      end
      chk("oe_at_most_one", ($countones(ifc.oe) <= 1), 1);
      if (ifc.rd_valid) begin
        exp_a = (addr + words) % 32;
        chk("burst_data", ifc.rd_data, regs[exp_a]);
        chk("burst_addr", ifc.rd_addr, exp_a);
        chk("burst_last", ifc.rd_last, (words == cnt));
        if (words == cnt) begin
          done = 1;
          last_cyc = cyc;
        end
        words++;
      end
      tick();
      cyc++;
    end
    ifc.req_valid = 1'b0;
    ifc.rd_ready  = 1'b0;
    chk("burst_done_in_budget", done, 1);
  endtask

  int words, last_cyc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    clr_n = 1'b0;
    ifc.req_valid = 1'b0; ifc.req_addr = '0; ifc.req_cnt = '0; ifc.rd_ready = 1'b0;
    ifc0.req_valid = 1'b0; ifc0.req_addr = '0; ifc0.req_cnt = '0; ifc0.rd_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", ifc.req_ready, 1);
    chk("rst_oe", ifc.oe, 0);
    chk("rst_rd_valid", ifc.rd_valid, 0);
    chk("rst_rd_data", ifc.rd_data, 0);
    chk("rst_rd_last", ifc.rd_last, 0);
    clr_n = 1'b1;
    tick();

    // Single read of register 5.
    regs[5] = 32'hDEADBEEF;
    ifc.req_valid = 1'b1; ifc.req_addr = 5'd5; ifc.req_cnt = 5'd0;
    tick();
    ifc.req_valid = 1'b0;
    chk("single_oe_c1", ifc.oe, 32'h1 << 5);
    chk("single_req_ready_busy", ifc.req_ready, 0);
    chk("single_rd_valid_c1", ifc.rd_valid, 0);
    tick();
    chk("single_oe_c2", ifc.oe, 32'h1 << 5);
    tick();
    chk("single_oe_hold", ifc.oe, 0);
    chk("single_rd_valid", ifc.rd_valid, 1);
    chk("single_rd_data", ifc.rd_data, 32'hDEADBEEF);
    chk("single_rd_addr", ifc.rd_addr, 5);
    chk("single_rd_last", ifc.rd_last, 1);
    ifc.rd_ready = 1'b1;
    tick();
    ifc.rd_ready = 1'b0;
    chk("single_req_ready_after", ifc.req_ready, 1);
    chk("single_rd_valid_after", ifc.rd_valid, 0);
    regs[5] = 32'd5;

    // Wrap burst 30,31,0,1.
    do_burst(30, 3, -1, words, last_cyc);
    chk("wrap_words", words, 4);
    chk("wrap_last_cycle", last_cyc, 12);
    chk("wrap_req_ready_after", ifc.req_ready, 1);

    // Back-pressure on a 2-word burst.
    ifc.req_valid = 1'b1; ifc.req_addr = 5'd10; ifc.req_cnt = 5'd1;
    tick();
    ifc.req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("stall_rd_valid", ifc.rd_valid, 1);
      chk("stall_rd_data", ifc.rd_data, 10);
      chk("stall_oe", ifc.oe, 0);
      tick();
    end
    ifc.rd_ready = 1'b1;
    tick();
    ifc.rd_ready = 1'b0;
    chk("stall_w2_oe", ifc.oe, 32'h1 << 11);
    tick(); tick();
    chk("stall_w2_valid", ifc.rd_valid, 1);
    chk("stall_w2_data", ifc.rd_data, 11);
    chk("stall_w2_addr", ifc.rd_addr, 11);
    chk("stall_w2_last", ifc.rd_last, 1);
    ifc.rd_ready = 1'b1;
    tick();
    ifc.rd_ready = 1'b0;
    chk("stall_idle", ifc.req_ready, 1);

    // Full 32-word burst with a stray request mid-way.
    do_burst(0, 31, 40, words, last_cyc);
    chk("full_words", words, 32);
    chk("full_last_cycle", last_cyc, 96);
    chk("full_req_ready_after", ifc.req_ready, 1);

    // Reset during DRIVE of word 2.
    ifc.req_valid = 1'b1; ifc.req_addr = 5'd3; ifc.req_cnt = 5'd2; ifc.rd_ready = 1'b1;
    tick();
    ifc.req_valid = 1'b0;
    tick(); tick(); tick();
    chk("rstmid_oe_w2", ifc.oe, 32'h1 << 4);
    clr_n = 1'b0;
    tick();
    chk("rstmid_oe", ifc.oe, 0);
    chk("rstmid_rd_valid", ifc.rd_valid, 0);
    chk("rstmid_rd_data", ifc.rd_data, 0);
    chk("rstmid_req_ready", ifc.req_ready, 1);
    clr_n = 1'b1;
    ifc.rd_ready = 1'b0;
    tick();
    chk("rstmid_no_oe", ifc.oe, 0);
    chk("rstmid_no_valid", ifc.rd_valid, 0);
    do_burst(20, 0, -1, words, last_cyc);
    chk("rstmid_fresh_words", words, 1);
    chk("rstmid_fresh_latency", last_cyc, 3);

    // SETTLE=0 instance: one-cycle oe and 2-cycle latency.
    ifc0.req_valid = 1'b1; ifc0.req_addr = 5'd9; ifc0.req_cnt = 5'd1; ifc0.rd_ready = 1'b1;
    tick();
    ifc0.req_valid = 1'b0;
    chk("s0_oe_w1", ifc0.oe, 32'h1 << 9);
    chk("s0_valid_c1", ifc0.rd_valid, 0);
    tick();
    chk("s0_oe_gap", ifc0.oe, 0);
    chk("s0_valid_w1", ifc0.rd_valid, 1);
    chk("s0_data_w1", ifc0.rd_data, 9);
    chk("s0_last_w1", ifc0.rd_last, 0);
    tick();
    chk("s0_oe_w2", ifc0.oe, 32'h1 << 10);
    tick();
    chk("s0_data_w2", ifc0.rd_data, 10);
    chk("s0_addr_w2", ifc0.rd_addr, 10);
    chk("s0_last_w2", ifc0.rd_last, 1);
    tick();
    ifc0.rd_ready = 1'b0;
    chk("s0_idle", ifc0.req_ready, 1);
    chk("s0_idle_oe", ifc0.oe, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
